// File: rtl/if_id_elastic_reg.sv
// ---------------------------------------------------------------------------
// IF/ID elastic pipeline register.
// Main register plus one skid entry, valid/ready on both sides. The upstream
// ready is a flop, so decode back-pressure never reaches fetch combinationally.
// A redirect (i_req) loads HANDLER_PC as a bubble. A flush empties the register
// and keeps the PC.
// Optional macro IF_ID_PERF_CNT_EN enables the o_stall_cycles counter.
// Without the macro, o_stall_cycles is tied to zero.
// ---------------------------------------------------------------------------
module if_id_elastic_reg #(
   parameter int                PC_W       = 32,
   parameter int                INSTR_W    = 32,
   parameter int                EXC_W      = 5,
   parameter logic [PC_W-1:0]   RESET_PC   = 32'h0000_3000,
   parameter logic [PC_W-1:0]   HANDLER_PC = 32'h0000_4180,
   parameter logic [EXC_W-1:0]  EXC_NONE   = '0
) (
   input  logic               clk,
   input  logic               reset,
   input  logic               i_in_valid,
   output logic               o_in_ready,
   input  logic [PC_W-1:0]    i_in_pc,
   input  logic [INSTR_W-1:0] i_in_instr,
   input  logic               i_in_is_delay,
   input  logic [EXC_W-1:0]   i_in_exc,
   output logic               o_out_valid,
   input  logic               i_out_ready,
   output logic [PC_W-1:0]    o_out_pc,
   output logic [INSTR_W-1:0] o_out_instr,
   output logic               o_out_is_delay,
   output logic [EXC_W-1:0]   o_out_exc,
   input  logic               i_flush,
   input  logic               i_req,
   output logic [31:0]        o_stall_cycles
);

   typedef enum logic [1:0] {EMPTY, ONE, TWO} state_t;

   state_t               r_state;
   state_t               w_nextState;
   logic                 r_inReady;
   logic [PC_W-1:0]      r_mainPc;
   logic [INSTR_W-1:0]   r_mainInstr;
   logic                 r_mainIsDelay;
   logic [EXC_W-1:0]     r_mainExc;
   logic [PC_W-1:0]      r_skidPc;
   logic [INSTR_W-1:0]   r_skidInstr;
   logic                 r_skidIsDelay;
   logic [EXC_W-1:0]     r_skidExc;
   logic                 w_outValid;
   logic                 w_inFire;
   logic                 w_outFire;
   logic                 w_loadMainIn;
   logic                 w_loadMainSkid;
   logic                 w_loadSkid;

   assign w_outValid = (r_state != EMPTY);
   assign w_inFire   = i_in_valid & r_inReady;
   assign w_outFire  = w_outValid & i_out_ready;

   // Pick the next occupancy and the data moves. Redirect beats flush, and
   // flush beats the handshake.
   always_comb begin
      w_nextState    = r_state;
      w_loadMainIn   = 1'b0;
      w_loadMainSkid = 1'b0;
      w_loadSkid     = 1'b0;
      if (i_req || i_flush) begin
         w_nextState = EMPTY;
      end else begin
         case (r_state)
            EMPTY: begin
               if (w_inFire) begin
                  w_loadMainIn = 1'b1;
                  w_nextState  = ONE;
               end
            end
            ONE: begin
               if (w_inFire && w_outFire) begin
                  w_loadMainIn = 1'b1;
               end else if (w_inFire) begin
                  w_loadSkid  = 1'b1;
                  w_nextState = TWO;
               end else if (w_outFire) begin
                  w_nextState = EMPTY;
               end
            end
            TWO: begin
               if (w_outFire) begin
                  w_loadMainSkid = 1'b1;
                  w_nextState    = ONE;
               end
            end
            default: w_nextState = EMPTY;
         endcase
      end
   end

   // Occupancy state and the registered upstream ready.
   always_ff @(posedge clk) begin
      if (reset) begin
         r_state   <= EMPTY;
         r_inReady <= 1'b1;
      end else begin
         r_state   <= w_nextState;
         r_inReady <= (w_nextState != TWO);
      end
   end

   // Main register. Redirect and flush scrub the payload into a clean bubble.
   always_ff @(posedge clk) begin
      if (reset) begin
         r_mainPc      <= RESET_PC;
         r_mainInstr   <= '0;
         r_mainIsDelay <= 1'b0;
         r_mainExc     <= EXC_NONE;
      end else if (i_req) begin
         r_mainPc      <= HANDLER_PC;
         r_mainInstr   <= '0;
         r_mainIsDelay <= 1'b0;
         r_mainExc     <= EXC_NONE;
      end else if (i_flush) begin
         r_mainInstr   <= '0;
         r_mainIsDelay <= 1'b0;
         r_mainExc     <= EXC_NONE;
      end else if (w_loadMainIn) begin
         r_mainPc      <= i_in_pc;
         r_mainInstr   <= i_in_instr;
         r_mainIsDelay <= i_in_is_delay;
         r_mainExc     <= i_in_exc;
      end else if (w_loadMainSkid) begin
         r_mainPc      <= r_skidPc;
         r_mainInstr   <= r_skidInstr;
         r_mainIsDelay <= r_skidIsDelay;
         r_mainExc     <= r_skidExc;
      end
   end

   // Skid entry. It only matters in TWO, so emptying the state discards it.
   always_ff @(posedge clk) begin
      if (reset) begin
         r_skidPc      <= '0;
         r_skidInstr   <= '0;
         r_skidIsDelay <= 1'b0;
         r_skidExc     <= EXC_NONE;
      end else if (w_loadSkid) begin
         r_skidPc      <= i_in_pc;
         r_skidInstr   <= i_in_instr;
         r_skidIsDelay <= i_in_is_delay;
         r_skidExc     <= i_in_exc;
      end
   end

   assign o_in_ready     = r_inReady;
   assign o_out_valid    = w_outValid;
   assign o_out_pc       = r_mainPc;
   assign o_out_instr    = r_mainInstr;
   assign o_out_is_delay = r_mainIsDelay;
   assign o_out_exc      = r_mainExc;

`ifdef IF_ID_PERF_CNT_EN
   logic [31:0] r_stallCycles;

   // Count cycles where decode holds off a valid entry. Only reset clears it.
   always_ff @(posedge clk) begin
      if (reset) begin
         r_stallCycles <= '0;
      end else if (w_outValid && !i_out_ready) begin
         r_stallCycles <= r_stallCycles + 32'd1;
      end
   end

   assign o_stall_cycles = r_stallCycles;
`else
   assign o_stall_cycles = '0;
`endif

endmodule

// File: tb/tb_if_id_elastic_reg.sv
// ---------------------------------------------------------------------------
// Testbench for if_id_elastic_reg.
// The reference model is a queue of at most two held entries plus the
// last-shown main payload. Directed steps come first, then random traffic.
// ---------------------------------------------------------------------------
module tb_if_id_elastic_reg;

   typedef struct {
      logic [31:0] pc;
      logic [31:0] instr;
      logic        dly;
      logic [4:0]  exc;
   } entry_t;

   logic        clk = 1'b0;
   logic        reset = 1'b1;
   logic        inValid = 1'b0;
   logic        inReady;
   logic [31:0] inPc = '0;
   logic [31:0] inInstr = '0;
   logic        inIsDelay = 1'b0;
   logic [4:0]  inExc = '0;
   logic        outValid;
   logic        outReady = 1'b0;
   logic [31:0] outPc;
   logic [31:0] outInstr;
   logic        outIsDelay;
   logic [4:0]  outExc;
   logic        flush = 1'b0;
   logic        req = 1'b0;
   logic [31:0] stallCycles;

   int errors = 0;
   int checks = 0;

   entry_t      q[$];
   entry_t      last;
   logic [31:0] modelStall;
   logic        modelInFire;

   if_id_elastic_reg dut (
      .clk            (clk),
      .reset          (reset),
      .i_in_valid     (inValid),
      .o_in_ready     (inReady),
      .i_in_pc        (inPc),
      .i_in_instr     (inInstr),
      .i_in_is_delay  (inIsDelay),
      .i_in_exc       (inExc),
      .o_out_valid    (outValid),
      .i_out_ready    (outReady),
      .o_out_pc       (outPc),
      .o_out_instr    (outInstr),
      .o_out_is_delay (outIsDelay),
      .o_out_exc      (outExc),
      .i_flush        (flush),
      .i_req          (req),
      .o_stall_cycles (stallCycles)
   );

   // Free-running clock.
   always #5 clk = ~clk;

   // Advance the model by one clock edge. It uses the inputs applied before the edge.
   task automatic modelUpdate();
      logic inFire;
      logic outFire;
      inFire  = inValid && (q.size() < 2);
      outFire = (q.size() > 0) && outReady;
      modelInFire = 1'b0;
      if (reset) begin
         q.delete();
         last = '{pc: 32'h0000_3000, instr: 32'h0, dly: 1'b0, exc: 5'd0};
         modelStall = 32'd0;
      end else begin
         if (q.size() > 0 && !outReady) modelStall = modelStall + 32'd1;
         if (req) begin
            q.delete();
            last = '{pc: 32'h0000_4180, instr: 32'h0, dly: 1'b0, exc: 5'd0};
         end else if (flush) begin
            q.delete();
            last.instr = 32'h0;
            last.dly   = 1'b0;
            last.exc   = 5'd0;
         end else begin
            if (outFire) void'(q.pop_front());
            if (inFire) begin
               q.push_back('{pc: inPc, instr: inInstr, dly: inIsDelay, exc: inExc});
               modelInFire = 1'b1;
            end
            if (q.size() > 0) last = q[0];
         end
      end
   endtask

   task automatic checkOne(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      assert (act === exp) else begin
         errors++;
         $error("FAIL %s: observed %h expected %h", name, act, exp);
      end
   endtask

   task automatic checkOutput(input string tag);
      logic [31:0] expStall;
`ifdef IF_ID_PERF_CNT_EN
      expStall = modelStall;
`else
      expStall = 32'd0;
`endif
      checkOne({tag, ".out_valid"}, {31'd0, outValid}, {31'd0, q.size() > 0});
      checkOne({tag, ".in_ready"}, {31'd0, inReady}, {31'd0, q.size() < 2});
      checkOne({tag, ".out_pc"}, outPc, last.pc);
      checkOne({tag, ".out_instr"}, outInstr, last.instr);
      checkOne({tag, ".out_is_delay"}, {31'd0, outIsDelay}, {31'd0, last.dly});
      checkOne({tag, ".out_exc"}, {27'd0, outExc}, {27'd0, last.exc});
      checkOne({tag, ".stall_cycles"}, stallCycles, expStall);
   endtask

   // Drive one cycle of inputs, clock it, then compare with the model 1 ns after the edge.
   task automatic applyStimulus(input string tag, input logic rst, input logic vld,
                                input logic [31:0] pc, input logic [31:0] instr,
                                input logic dly, input logic [4:0] exc,
                                input logic ordy, input logic fl, input logic rq);
      reset = rst; inValid = vld; inPc = pc; inInstr = instr;
      inIsDelay = dly; inExc = exc; outReady = ordy; flush = fl; req = rq;
      @(posedge clk);
      modelUpdate();
      #1;
      checkOutput(tag);
   endtask

   // Directed scenarios first, then constrained-random traffic.
   initial begin
      logic        pend;
      logic        vld;
      logic [31:0] pc;
      logic [31:0] instr;
      logic        dly;
      logic [4:0]  exc;
      logic        rst;
      logic        fl;
      logic        rq;

      $display("[TB] start");
      applyStimulus("reset0", 1, 0, 0, 0, 0, 0, 0, 0, 0);
      applyStimulus("reset1", 1, 0, 0, 0, 0, 0, 0, 0, 0);

      // Streaming: one entry per cycle with decode always ready.
      applyStimulus("stream0", 0, 1, 32'h3004, 32'h2401_0001, 0, 0, 1, 0, 0);
      checkOne("stream0.pc_direct", outPc, 32'h3004);
      applyStimulus("stream1", 0, 1, 32'h3008, 32'h2401_0002, 0, 0, 1, 0, 0);
      applyStimulus("stream2", 0, 0, 0, 0, 0, 0, 1, 0, 0);

      // Fill to TWO under back-pressure, then drain in order.
      applyStimulus("fillA", 0, 1, 32'h3008, 32'hA, 0, 0, 0, 0, 0);
      applyStimulus("fillB", 0, 1, 32'h300C, 32'hB, 0, 0, 0, 0, 0);
      checkOne("fillB.in_ready_low", {31'd0, inReady}, 32'd0);
      applyStimulus("drainA", 0, 0, 0, 0, 0, 0, 1, 0, 0);
      checkOne("drainA.pc_is_B", outPc, 32'h300C);
      applyStimulus("drainB", 0, 0, 0, 0, 0, 0, 1, 0, 0);

      // Redirect while holding two entries.
      applyStimulus("refillA", 0, 1, 32'h3008, 32'hA, 0, 0, 0, 0, 0);
      applyStimulus("refillB", 0, 1, 32'h300C, 32'hB, 0, 0, 0, 0, 0);
      applyStimulus("req", 0, 1, 32'h3010, 32'hC, 0, 0, 1, 0, 1);
      checkOne("req.pc_direct", outPc, 32'h4180);
      applyStimulus("postReq", 0, 0, 0, 0, 0, 0, 1, 0, 0);

      // Flush in ONE keeps the PC and drops the offered input.
      applyStimulus("one", 0, 1, 32'h3010, 32'h1234_5678, 0, 0, 0, 0, 0);
      applyStimulus("flush", 0, 1, 32'h3014, 32'h9, 0, 0, 0, 1, 0);
      checkOne("flush.pc_kept", outPc, 32'h3010);

      // Exception payload, then req and flush together.
      applyStimulus("exc", 0, 1, 32'h3018, 32'h77, 1, 5'd4, 0, 0, 0);
      applyStimulus("reqFlush", 0, 0, 0, 0, 0, 0, 0, 1, 1);

      // Seven stalled cycles with one valid entry held.
      applyStimulus("stallRst", 1, 0, 0, 0, 0, 0, 0, 0, 0);
      applyStimulus("stallLoad", 0, 1, 32'h301C, 32'h5, 0, 0, 0, 0, 0);
      for (int i = 0; i < 7; i++) applyStimulus("stall", 0, 0, 0, 0, 0, 0, 0, 0, 0);
`ifdef IF_ID_PERF_CNT_EN
      checkOne("stall.count7", stallCycles, 32'd7);
`else
      checkOne("stall.count0", stallCycles, 32'd0);
`endif

      // Random traffic. Offered data stays stable until it fires or is withdrawn.
      pend = 1'b0;
      pc = 0; instr = 0; dly = 0; exc = 0;
      for (int i = 0; i < 600; i++) begin
         if (pend) begin
            vld = ($urandom_range(0, 7) != 0);
         end else begin
            vld   = ($urandom_range(0, 3) != 0);
            pc    = $urandom;
            instr = $urandom;
            dly   = 1'($urandom_range(0, 1));
            exc   = 5'($urandom_range(0, 31));
         end
         rst = ($urandom_range(0, 99) == 0);
         fl  = ($urandom_range(0, 24) == 0);
         rq  = ($urandom_range(0, 29) == 0);
         applyStimulus("rand", rst, vld, pc, instr, dly, exc,
                       ($urandom_range(0, 2) != 0), fl, rq);
         pend = vld && !modelInFire && !rst && !fl && !rq;
      end

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
